q_policy_walker: RTL and testbench
==================================

// Module: q_policy_walker
// PURPOSE
// - Downstream of the Q-learning core. After training, walks the greedy policy from
//   start_state to target_state over the final Q-table and streams one action per step.
// - Reads the table through a 1-cycle-latency read port (table RAM or register-file mux).
// - Output stream drives the maze controller / display.
// - Ends each walk with a status: reached target, step limit hit (loop), or boxed in.
// PARAMETERS
// - ROWS       6    maze rows
// - COLS       6    maze columns; cell states 0..ROWS*COLS-1, state ROWS*COLS = invalid/off-grid
// - QW         32   Q-value width, two's-complement signed
// - MAX_STEPS  64   step limit before status LOOP; must be <= 2**SW-1
// - SW         7    width of path_len
// PORTS
// - clk           in   1       clock, rising edge
// - rst           in   1       asynchronous, active-high reset
// - start         in   1       1-cycle pulse: begin a walk; ignored while busy=1
// - start_state   in   6       sampled on start
// - target_state  in   6       sampled on start
// - blocked_mask  in   ROWS*COLS  bit s=1: cell s impassable; held stable while busy
// - q_rd_en       out  1       Q-table read strobe
// - q_rd_state    out  6       read address: state
// - q_rd_action   out  2       read address: action
// - q_rd_data     in   QW      data for the read issued in the previous cycle
// - act_valid     out  1       action beat valid
// - act_ready     in   1       consumer accepts the beat
// - act_dir       out  2       0=up (s-COLS), 1=down (s+COLS), 2=left (s-1), 3=right (s+1)
// - act_state     out  6       state the action is taken from
// - act_last      out  1       beat whose next state is target_state
// - busy          out  1       walk in progress
// - done          out  1       1-cycle pulse when the walk ends
// - status        out  2       0=OK, 1=LOOP, 2=BOXED; valid with done, held until next start
// - path_len      out  SW      beats accepted in the walk; valid with done, held
// BEHAVIOUR
// - Reset: FSM=IDLE. All outputs 0; q_rd_* address outputs 0.
// - FSM states: IDLE -> CHECK -> READ -> EMIT -> CHECK ... -> FIN -> IDLE.
// - IDLE: on start, latch start_state/target_state, cur=start_state, steps=0, busy=1,
//   go to CHECK.
// - CHECK (1 cycle):
//   - cur==target -> FIN with OK.
//   - steps==MAX_STEPS -> FIN with LOOP.
//   - otherwise -> READ.
// - READ (5 cycles):
//   - Issue q_rd_en for actions 0,1,2,3 on consecutive cycles (q_rd_state=cur).
//   - Compare each q_rd_data one cycle after its read; the last compare lands in the 5th cycle.
//   - An action is a candidate only if its neighbour is on-grid and not blocked.
//     Off-grid means: the row moves outside 0..ROWS-1, or a left/right move crosses a row edge.
//   - Argmax is a signed compare; a strict > is needed to replace the best, so ties go to
//     the lowest action index.
//   - No candidate -> FIN with BOXED, nothing emitted.
//   - Otherwise -> EMIT.
// - EMIT: act_valid=1 with act_dir, act_state=cur and act_last=(next==target).
//   - act_* stay stable until act_valid&&act_ready.
//   - On acceptance: cur=next, steps+=1, go to CHECK.
//   - act_valid never drops without a handshake.
// - FIN (1 cycle): done=1, busy=0, status and path_len=steps updated, then IDLE.
// - Latency: with act_ready tied 1, each step takes 7 cycles (CHECK 1 + READ 5 + EMIT 1).
//   From start, the first act_valid appears 7 cycles later (IDLE exit 1 + CHECK 1 + READ 5).
// - start_state==target_state: done 2 cycles after start, status OK, path_len 0, no beats.
// - A start with start_state invalid (>=ROWS*COLS) or blocked ends as BOXED with path_len 0.
// - start while busy is ignored. A start in the FIN cycle is also ignored.
// - Async rst mid-walk: immediate return to IDLE with all outputs 0; a pending beat is dropped.
// - A Q-table update while busy is not supported. The upstream core holds the table
//   frozen whenever busy=1.
// STRUCTURE
// - Package q_maze_pkg:
//   - ROWS, COLS, NUM_STATES=ROWS*COLS+1, INVALID_STATE.
//   - typedef enum action_t {UP,DOWN,LEFT,RIGHT}.
//   - typedef enum walk_status_t {OK,LOOP,BOXED}.
//   - typedef logic signed [QW-1:0] q_t.
// - Sub-module q_next_state (combinational): (state, action) -> next state or INVALID_STATE.
//   Shared with the learning-side trial logic.
// - Top: FSM, read sequencer, argmax registers (best_q, best_a, have_cand), step counter.
// TESTING
// - Empty 6x6, Q favours right then down, start 0, target 35 ->
//   10 beats (5 right, 5 down), act_last on beat 10, status OK, path_len 10.
// - Q(14,LEFT)=Q(14,RIGHT)=100 (signed), all others -5 -> beat from 14 is dir 2 (tie to lowest).
// - Q policy 7->8->7 cycle, target 35 -> no done until 64 accepted beats, then status LOOP.
// - start 7 with all four neighbours blocked -> no beats, done, status BOXED, path_len 0.
// - act_ready held 0 for 20 cycles mid-walk -> act_* stable throughout, no q_rd_en issued.
// - start_state==target_state=20 -> done 2 cycles after start, status OK, path_len 0.
// - rst asserted during EMIT -> outputs 0 at once; next start walks from scratch.

Source files
------------

// File: rtl/q_policy_walker_pkg.sv
// Shared maze constants and types for the Q-learning core and the policy walker.
package q_maze_pkg;

  localparam int unsigned ROWS          = 6;
  localparam int unsigned COLS          = 6;
  localparam int unsigned NUM_STATES    = ROWS * COLS + 1;
  localparam int unsigned INVALID_STATE = NUM_STATES - 1;
  localparam int unsigned STW           = 6;
  localparam int unsigned QW            = 32;

  typedef logic [STW-1:0] state_t;
  typedef logic signed [QW-1:0] q_t;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} action_t;
  typedef enum logic [1:0] {OK, LOOP, BOXED} walk_status_t;

  localparam state_t INVALID_ST = state_t'(INVALID_STATE);

endpackage

// File: rtl/q_policy_walker_if.sv
// Q-table read port and action stream of the policy walker.
import q_maze_pkg::*;

interface q_policy_walker_if #(
  parameter int unsigned QW = 32
);
  logic          q_rd_en;
  state_t        q_rd_state;
  logic [1:0]    q_rd_action;
  logic [QW-1:0] q_rd_data;

  logic          act_valid;
  logic          act_ready;
  logic [1:0]    act_dir;
  state_t        act_state;
  logic          act_last;

  // Walker side
  modport master (
    output q_rd_en, q_rd_state, q_rd_action,
    input  q_rd_data,
    output act_valid, act_dir, act_state, act_last,
    input  act_ready
  );

  // Table / consumer side
  modport slave (
    input  q_rd_en, q_rd_state, q_rd_action,
    output q_rd_data,
    input  act_valid, act_dir, act_state, act_last,
    output act_ready
  );
endinterface

// File: rtl/q_policy_walker_next_state.sv
// Maze move: (state, action) -> neighbour state, or INVALID_ST when off-grid.
import q_maze_pkg::*;

module q_next_state (
  input  state_t  state_i,
  input  action_t action_i,
  output state_t  next_o
);

  logic [31:0] s_w;
  logic [31:0] row_w;
  logic [31:0] col_w;

  // Row/column bounds decide whether the move stays on the grid
  always_comb begin
    next_o = INVALID_ST;
    s_w    = 32'(state_i);
    row_w  = s_w / COLS;
    col_w  = s_w % COLS;
    if (s_w < ROWS * COLS) begin
      unique case (action_i)
        UP:    if (row_w > 0)        next_o = state_t'(s_w - COLS);
        DOWN:  if (row_w < ROWS - 1) next_o = state_t'(s_w + COLS);
        LEFT:  if (col_w > 0)        next_o = state_t'(s_w - 1);
        RIGHT: if (col_w < COLS - 1) next_o = state_t'(s_w + 1);
        default: next_o = INVALID_ST;
      endcase
    end
  end

endmodule

// File: rtl/q_policy_walker.sv
// Greedy policy walker: follows argmax-Q actions from start to target over a frozen Q-table.
import q_maze_pkg::*;

module q_policy_walker #(
  parameter int unsigned QW        = 32,
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned SW        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  state_t               start_state,
  input  state_t               target_state,
  input  logic [ROWS*COLS-1:0] blocked_mask,
  q_policy_walker_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [SW-1:0]        path_len
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_EMIT, S_FIN} fsm_t;

  fsm_t                  state_q;
  state_t                cur_q;
  state_t                tgt_q;
  logic [SW-1:0]         steps_q;
  logic [2:0]            rd_cnt_q;
  logic signed [QW-1:0]  bestq_q;
  action_t               best_a_q;
  state_t                best_nxt_q;
  logic                  have_cand_q;

  action_t               cmp_a;
  state_t                nbr;
  logic                  cur_blk;
  logic                  cand;
  logic                  take;
  logic                  fin_have;
  action_t               fin_a;
  state_t                fin_nxt;

  // Neighbour of the action whose read data is arriving this cycle
  q_next_state u_next (
    .state_i  (cur_q),
    .action_i (cmp_a),
    .next_o   (nbr)
  );

  // Argmax step: read data lags the read strobe by one cycle, so read count k compares action k-1
  always_comb begin
    cmp_a    = action_t'(rd_cnt_q[1:0] - 2'd1);
    cur_blk  = (cur_q < INVALID_ST) && blocked_mask[cur_q];
    cand     = (nbr != INVALID_ST) && !blocked_mask[nbr] && !cur_blk;
    take     = (state_q == S_READ) && (rd_cnt_q != 3'd0) && cand &&
               (!have_cand_q || ($signed(bus.q_rd_data) > bestq_q));
    fin_have = have_cand_q | take;
    fin_a    = take ? cmp_a : best_a_q;
    fin_nxt  = take ? nbr   : best_nxt_q;
  end

  // Walk FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cur_q           <= '0;
      tgt_q           <= '0;
      steps_q         <= '0;
      rd_cnt_q        <= '0;
      bestq_q         <= '0;
      best_a_q        <= UP;
      best_nxt_q      <= '0;
      have_cand_q     <= 1'b0;
      bus.q_rd_en     <= 1'b0;
      bus.q_rd_state  <= '0;
      bus.q_rd_action <= '0;
      bus.act_valid   <= 1'b0;
      bus.act_dir     <= '0;
      bus.act_state   <= '0;
      bus.act_last    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      status          <= '0;
      path_len        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cur_q   <= start_state;
            tgt_q   <= target_state;
            steps_q <= '0;
            busy    <= 1'b1;
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cur_q == tgt_q) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            status   <= OK;
            path_len <= steps_q;
            state_q  <= S_FIN;
          end else if (steps_q == SW'(MAX_STEPS)) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            status   <= LOOP;
            path_len <= steps_q;
            state_q  <= S_FIN;
          end else begin
            rd_cnt_q        <= '0;
            have_cand_q     <= 1'b0;
            bus.q_rd_en     <= 1'b1;
            bus.q_rd_state  <= cur_q;
            bus.q_rd_action <= UP;
            state_q         <= S_READ;
          end
        end

        S_READ: begin
          rd_cnt_q    <= rd_cnt_q + 3'd1;
          have_cand_q <= fin_have;
          best_a_q    <= fin_a;
          best_nxt_q  <= fin_nxt;
          if (take) bestq_q <= $signed(bus.q_rd_data);
          if (rd_cnt_q < 3'd3) begin
            bus.q_rd_action <= rd_cnt_q[1:0] + 2'd1;
          end else begin
            bus.q_rd_en <= 1'b0;
          end
          if (rd_cnt_q == 3'd4) begin
            if (fin_have) begin
              bus.act_valid <= 1'b1;
              bus.act_dir   <= fin_a;
              bus.act_state <= cur_q;
              bus.act_last  <= (fin_nxt == tgt_q);
              state_q       <= S_EMIT;
            end else begin
              done     <= 1'b1;
              busy     <= 1'b0;
              status   <= BOXED;
              path_len <= steps_q;
              state_q  <= S_FIN;
            end
          end
        end

        S_EMIT: begin
          if (bus.act_ready) begin
            bus.act_valid <= 1'b0;
            cur_q         <= best_nxt_q;
            steps_q       <= steps_q + 1'b1;
            state_q       <= S_CHECK;
          end
        end

        S_FIN: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_policy_walker.sv
// Scoreboard bench for q_policy_walker: directed walks over small hand-built Q-tables.
import q_maze_pkg::*;

module tb_q_policy_walker;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [5:0]           start_state = '0;
  logic [5:0]           target_state = '0;
  logic [ROWS*COLS-1:0] blocked_mask = '0;
  logic                 busy, done;
  logic [1:0]           status;
  logic [6:0]           path_len;

  q_policy_walker_if #(.QW(32)) bif ();

  q_policy_walker #(.QW(32), .MAX_STEPS(64), .SW(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_state  (start_state),
    .target_state (target_state),
    .blocked_mask (blocked_mask),
    .bus          (bif),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .path_len     (path_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = 0;

  function automatic logic [31:0] q_val(int m, int s, int a);
    case (m)
      0: return (a == 3) ? 32'sd10 : (a == 1) ? 32'sd5 : 32'sd0;
      1: return (s == 14 && (a == 2 || a == 3)) ? 32'sd100 : -32'sd5;
      2: return (s == 14 && a == 0) ? 32'sd5 : -32'sd1;
      3: return ((s == 7 && a == 3) || (s == 8 && a == 2)) ? 32'sd10 : 32'sd0;
      default: return 32'sd0;
    endcase
  endfunction

  // Q-table with one cycle of read latency
  always @(posedge clk) begin
    if (bif.q_rd_en) bif.q_rd_data <= q_val(mode, int'(bif.q_rd_state), int'(bif.q_rd_action));
  end

  typedef struct { logic [1:0] dir; logic [5:0] st; logic last; } beat_t;
  typedef struct { logic [1:0] stat; int len; } fin_t;

  beat_t exp_beats[$];
  fin_t  exp_fins[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int start_cyc = 0;
  int first_valid_cyc = -1;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;
  int done_cyc = -1;
  logic hold_chk = 1'b0;

  task automatic chk(string nm, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    beat_t b;
    fin_t  f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_chk) begin
          chk("hold_valid", bif.act_valid, 1);
          chk("hold_dir",   bif.act_dir, 3);
          chk("hold_state", bif.act_state, 0);
          chk("hold_last",  bif.act_last, 0);
          chk("hold_no_rd", bif.q_rd_en, 0);
        end
        if (bif.act_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (bif.act_ready) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            beat_cnt++;
            if (exp_beats.size() == 0) begin
              chk("unexpected_beat", 1, 0);
            end else begin
              b = exp_beats.pop_front();
              chk("beat_dir",   bif.act_dir, b.dir);
              chk("beat_state", bif.act_state, b.st);
              chk("beat_last",  bif.act_last, b.last);
            end
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_fins.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            f = exp_fins.pop_front();
            chk("status",   status, f.stat);
            chk("path_len", path_len, f.len);
            chk("busy_at_done", busy, 0);
          end
        end
      end
    end
  endtask

  task automatic push_beat(int d, int s, int l);
    beat_t b;
    b.dir = 2'(d); b.st = 6'(s); b.last = l[0];
    exp_beats.push_back(b);
  endtask

  task automatic push_fin(int st, int len);
    fin_t f;
    f.stat = 2'(st); f.len = len;
    exp_fins.push_back(f);
  endtask

  task automatic do_start(int s, int t);
    @(posedge clk); #1;
    start = 1'b1; start_state = 6'(s); target_state = 6'(t);
    start_cyc = cyc; first_valid_cyc = -1; first_acc_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int n, int budget, string nm);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
    chk(nm, done_cnt, n);
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_busy"},   busy, 0);
    chk({nm, "_done"},   done, 0);
    chk({nm, "_status"}, status, 0);
    chk({nm, "_plen"},   path_len, 0);
    chk({nm, "_rd_en"},  bif.q_rd_en, 0);
    chk({nm, "_rd_st"},  bif.q_rd_state, 0);
    chk({nm, "_rd_act"}, bif.q_rd_action, 0);
    chk({nm, "_valid"},  bif.act_valid, 0);
    chk({nm, "_dir"},    bif.act_dir, 0);
    chk({nm, "_astate"}, bif.act_state, 0);
    chk({nm, "_last"},   bif.act_last, 0);
  endtask

  initial begin
    int n;
    bif.act_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Empty maze, right then down: 0 -> 35
    mode = 0; n = 0;
    for (int i = 0; i < 5; i++) push_beat(3, i, 0);
    for (int i = 0; i < 5; i++) push_beat(1, 5 + 6 * i, (i == 4) ? 1 : 0);
    push_fin(0, 10);
    do_start(0, 35);
    n++; wait_done(n, 200, "walk_done");
    chk("first_valid_latency", first_valid_cyc - start_cyc, 7);
    chk("step_spacing", last_acc_cyc - first_acc_cyc, 63);

    // Tie between LEFT and RIGHT goes to LEFT
    mode = 1;
    push_beat(2, 14, 1); push_fin(0, 1);
    do_start(14, 13);
    n++; wait_done(n, 100, "tie_done");

    // Signed compare: +5 must beat -1
    mode = 2;
    push_beat(0, 14, 1); push_fin(0, 1);
    do_start(14, 8);
    n++; wait_done(n, 100, "signed_done");

    // 7 <-> 8 cycle hits the step limit; a start mid-walk is ignored
    mode = 3;
    for (int i = 0; i < 64; i++) push_beat((i % 2 == 0) ? 3 : 2, (i % 2 == 0) ? 7 : 8, 0);
    push_fin(1, 64);
    do_start(7, 35);
    repeat (30) @(posedge clk);
    #1 start = 1'b1; start_state = 6'd20; target_state = 6'd20;
    @(posedge clk); #1 start = 1'b0;
    n++; wait_done(n, 600, "loop_done");
    chk("loop_beats", beat_cnt, 10 + 1 + 1 + 64);

    // Start==target: done two cycles later; a start in the FIN cycle is ignored
    push_fin(0, 0);
    do_start(20, 20);
    @(posedge clk); #1 start = 1'b1; start_state = 6'd0; target_state = 6'd2;
    @(posedge clk); #1 start = 1'b0;
    n++; wait_done(n, 20, "same_done");
    chk("same_latency", done_cyc - start_cyc, 2);
    repeat (20) @(posedge clk);
    #1 chk("fin_start_ignored", done_cnt, n);
    chk("fin_start_busy", busy, 0);

    // Boxed in at 7
    blocked_mask = '0;
    blocked_mask[1] = 1'b1; blocked_mask[6] = 1'b1;
    blocked_mask[8] = 1'b1; blocked_mask[13] = 1'b1;
    push_fin(2, 0);
    do_start(7, 35);
    n++; wait_done(n, 50, "boxed_done");
    chk("boxed_latency", done_cyc - start_cyc, 7);

    // Blocked start cell and off-grid start
    blocked_mask = '0; blocked_mask[0] = 1'b1;
    mode = 0;
    push_fin(2, 0);
    do_start(0, 35);
    n++; wait_done(n, 50, "blk_start_done");
    blocked_mask = '0;
    push_fin(2, 0);
    do_start(40, 35);
    n++; wait_done(n, 50, "inv_start_done");

    // Back-pressure: beat held 20 cycles with no reads
    mode = 0;
    push_beat(3, 0, 0); push_beat(3, 1, 1); push_fin(0, 2);
    @(posedge clk); #1 bif.act_ready = 1'b0;
    do_start(0, 2);
    for (int k = 0; k < 50 && !bif.act_valid; k++) @(posedge clk);
    @(posedge clk); #1 hold_chk = 1'b1;
    repeat (20) @(posedge clk);
    #1 hold_chk = 1'b0; bif.act_ready = 1'b1;
    n++; wait_done(n, 100, "bp_done");

    // Reset during EMIT drops the beat; next walk starts clean
    blocked_mask[1] = 1'b1; blocked_mask[6] = 1'b1;
    blocked_mask[8] = 1'b1; blocked_mask[13] = 1'b1;
    push_fin(2, 0);
    do_start(7, 35);
    n++; wait_done(n, 50, "pre_rst_done");
    blocked_mask = '0;
    @(posedge clk); #1 bif.act_ready = 1'b0;
    do_start(0, 35);
    for (int k = 0; k < 50 && !bif.act_valid; k++) @(posedge clk);
    @(posedge clk); #1;
    chk("rst_pre_valid", bif.act_valid, 1);
    chk("rst_pre_status", status, 2);
    rst = 1'b1;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bif.act_ready = 1'b1;
    push_beat(3, 0, 0); push_beat(3, 1, 1); push_fin(0, 2);
    do_start(0, 2);
    n++; wait_done(n, 100, "post_rst_done");
    chk("post_rst_latency", first_valid_cyc - start_cyc, 7);

    chk("beats_left", exp_beats.size(), 0);
    chk("fins_left", exp_fins.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
